cache_line_fill_buffer: RTL and testbench

Line fill buffer for the instruction/data cache miss path. On an enable from the cache controller it latches the missing word address and issues one wrapping read burst, critical word first, for the whole cache line. It reports the critical word as soon as it arrives, so the controller can release the processor stall early, then flags completion once the full line is assembled for the cache line write. It sits between the cache controller (LB_Enable / LB_FirstWord / LB_Completed / LineAddress) and the memory read port.

---
 rtl/cache_line_fill_buffer.sv | 182 ++++++++++++++++++
 tb/tb_cache_line_fill_buffer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_fill_buffer.sv
// Line fill buffer for the cache miss path: one critical-word-first
// wrap burst per miss, early critical word, then the assembled line.
module cache_line_fill_buffer #(
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 32
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        En,
  input  logic [ADDR_W-1:0]           WordAddress,
  output logic [ADDR_W-1:0]           LineAddress,
  output logic                        FirstWord,
  output logic [31:0]                 CrtData,
  output logic                        Completed,
  output logic [32*WORDS_PER_LINE-1:0] LineData,
  output logic                        Busy,
  output logic                        Err,
  output logic                        Mem_ReqValid,
  input  logic                        Mem_ReqReady,
  output logic [ADDR_W-1:0]           Mem_ReqAddr,
  output logic [7:0]                  Mem_ReqLen,
  input  logic                        Mem_RdValid,
  output logic                        Mem_RdReady,
  input  logic [31:0]                 Mem_RdData,
  input  logic                        Mem_RdLast
);

  localparam int IW = $clog2(WORDS_PER_LINE);
  localparam int LW = 32 * WORDS_PER_LINE;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [IW-1:0] LAST = IW'(WORDS_PER_LINE - 1);
  localparam logic [7:0] REQ_LEN = 8'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'(WORDS_PER_LINE * 4 - 1);
  localparam logic [ADDR_W-1:0] BYTE_MASK = ADDR_W'(3);

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     beat_q, beat_d;
  logic [IW-1:0]     crt_idx_q, crt_idx_d;
  logic              abort_q, abort_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [7:0]        req_len_q, req_len_d;
  logic              req_valid_q, req_valid_d;
  logic [31:0]       crt_data_q, crt_data_d;
  logic              first_word_q, first_word_d;
  logic              completed_q, completed_d;
  logic [LW-1:0]     line_data_q, line_data_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic          rd_ready;
  logic          beat_fire;
  logic          beat_last;
  logic [IW-1:0] slot;

  assign rd_ready  = (state_q == S_FILL) || (state_q == S_DRAIN);
  assign beat_fire = Mem_RdValid & rd_ready;
  assign beat_last = (beat_q == LAST);
  assign slot      = crt_idx_q + beat_q;

  // Next-state and datapath updates for the fill sequence.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    crt_idx_d    = crt_idx_q;
    abort_d      = abort_q;
    line_addr_d  = line_addr_q;
    req_addr_d   = req_addr_q;
    req_len_d    = req_len_q;
    crt_data_d   = crt_data_q;
    line_data_d  = line_data_q;
    err_d        = err_q;
    first_word_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (En) begin
          line_addr_d = WordAddress & ~OFF_MASK;
          req_addr_d  = WordAddress & ~BYTE_MASK;
          req_len_d   = REQ_LEN;
          crt_idx_d   = WordAddress[IW+1:2];
          line_data_d = '0;
          err_d       = 1'b0;
          beat_d      = '0;
          abort_d     = 1'b0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (!En) abort_d = 1'b1;
        if (Mem_ReqReady) begin
          state_d = (En && !abort_q) ? S_FILL : S_DRAIN;
        end
      end
      S_FILL: begin
        // A beat arriving while En is low is already a drained beat.
        if (beat_fire && En) begin
          for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (slot == IW'(i)) line_data_d[32*i +: 32] = Mem_RdData;
          end
          if (beat_q == '0) begin
            crt_data_d   = Mem_RdData;
            first_word_d = 1'b1;
          end
        end
        if (beat_fire) begin
          if (beat_last) state_d = En ? S_DONE : S_IDLE;
          else beat_d = beat_q + 1'b1;
        end
        if (!En && !(beat_fire && beat_last)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (beat_fire) begin
          if (beat_last) state_d = S_IDLE;
          else beat_d = beat_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!En) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (beat_fire && (Mem_RdLast != beat_last)) err_d = 1'b1;
    req_valid_d = (state_d == S_REQ);
    busy_d      = (state_d != S_IDLE);
    completed_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset returns everything to zero.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      crt_idx_q    <= '0;
      abort_q      <= 1'b0;
      line_addr_q  <= '0;
      req_addr_q   <= '0;
      req_len_q    <= '0;
      req_valid_q  <= 1'b0;
      crt_data_q   <= '0;
      first_word_q <= 1'b0;
      completed_q  <= 1'b0;
      line_data_q  <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      crt_idx_q    <= crt_idx_d;
      abort_q      <= abort_d;
      line_addr_q  <= line_addr_d;
      req_addr_q   <= req_addr_d;
      req_len_q    <= req_len_d;
      req_valid_q  <= req_valid_d;
      crt_data_q   <= crt_data_d;
      first_word_q <= first_word_d;
      completed_q  <= completed_d;
      line_data_q  <= line_data_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign LineAddress  = line_addr_q;
  assign FirstWord    = first_word_q;
  assign CrtData      = crt_data_q;
  assign Completed    = completed_q;
  assign LineData     = line_data_q;
  assign Busy         = busy_q;
  assign Err          = err_q;
  assign Mem_ReqValid = req_valid_q;
  assign Mem_ReqAddr  = req_addr_q;
  assign Mem_ReqLen   = req_len_q;
  assign Mem_RdReady  = rd_ready;

endmodule

// File: tb/tb_cache_line_fill_buffer.sv
// Bench for cache_line_fill_buffer: transaction-level model plus
// directed and randomized fills against a simple memory responder.
module tb_cache_line_fill_buffer;

  localparam int N = 8;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         En;
  logic [31:0]  WordAddress;
  logic [31:0]  LineAddress;
  logic         FirstWord;
  logic [31:0]  CrtData;
  logic         Completed;
  logic [255:0] LineData;
  logic         Busy;
  logic         Err;
  logic         Mem_ReqValid;
  logic         Mem_ReqReady;
  logic [31:0]  Mem_ReqAddr;
  logic [7:0]   Mem_ReqLen;
  logic         Mem_RdValid;
  logic         Mem_RdReady;
  logic [31:0]  Mem_RdData;
  logic         Mem_RdLast;

  cache_line_fill_buffer #(.WORDS_PER_LINE(N), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .WordAddress(WordAddress),
    .LineAddress(LineAddress), .FirstWord(FirstWord),
    .CrtData(CrtData), .Completed(Completed), .LineData(LineData),
    .Busy(Busy), .Err(Err), .Mem_ReqValid(Mem_ReqValid),
    .Mem_ReqReady(Mem_ReqReady), .Mem_ReqAddr(Mem_ReqAddr),
    .Mem_ReqLen(Mem_ReqLen), .Mem_RdValid(Mem_RdValid),
    .Mem_RdReady(Mem_RdReady), .Mem_RdData(Mem_RdData),
    .Mem_RdLast(Mem_RdLast)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [383:0] act,
                     input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_active = 0;
  bit          m_req = 0;
  bit          m_abort = 0;
  bit          m_burst = 0;
  bit          m_keep = 0;
  bit          m_done = 0;
  bit          m_first = 0;
  bit          m_err = 0;
  int          m_cnt = 0;
  int          m_crt = 0;
  logic [31:0] m_words [N];
  logic [31:0] m_crt_data = 0;
  logic [31:0] m_line_addr = 0;
  logic [31:0] m_req_addr = 0;
  logic [7:0]  m_req_len = 0;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_active = 0; m_req = 0; m_abort = 0; m_burst = 0;
      m_keep = 0; m_done = 0; m_first = 0; m_err = 0;
      m_cnt = 0; m_crt = 0; m_crt_data = 0;
      m_line_addr = 0; m_req_addr = 0; m_req_len = 0;
      for (int i = 0; i < N; i++) m_words[i] = 0;
    end else begin
      m_first = 0;
      if (!m_active) begin
        if (En) begin
          m_active = 1; m_req = 1; m_abort = 0;
          m_line_addr = WordAddress & ~32'h1F;
          m_req_addr = WordAddress & ~32'h3;
          m_req_len = 8'(N - 1);
          m_crt = int'(WordAddress[4:2]);
          m_cnt = 0; m_err = 0;
          for (int i = 0; i < N; i++) m_words[i] = 0;
        end
      end else if (m_req) begin
        if (!En) m_abort = 1;
        if (Mem_ReqReady) begin
          m_req = 0; m_burst = 1;
          m_keep = En && !m_abort;
        end
      end else if (m_burst) begin
        if (Mem_RdValid) begin
          if (Mem_RdLast != (m_cnt == N - 1)) m_err = 1;
          if (m_keep && En) begin
            m_words[(m_crt + m_cnt) % N] = Mem_RdData;
            if (m_cnt == 0) begin
              m_first = 1;
              m_crt_data = Mem_RdData;
            end
          end
          if (m_cnt == N - 1) begin
            m_burst = 0;
            if (m_keep && En) m_done = 1;
            else m_active = 0;
          end else begin
            m_cnt++;
          end
        end
        if (!En) m_keep = 0;
      end else if (m_done) begin
        if (!En) begin
          m_done = 0; m_active = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model -------------
  always @(negedge Clk) begin : cmp
    logic [255:0] ml;
    for (int i = 0; i < N; i++) ml[32*i +: 32] = m_words[i];
    chk("busy", 384'(Busy), 384'(m_active));
    chk("req_valid", 384'(Mem_ReqValid), 384'(m_req));
    chk("rd_ready", 384'(Mem_RdReady), 384'(m_burst));
    chk("completed", 384'(Completed), 384'(m_done));
    chk("first_word", 384'(FirstWord), 384'(m_first));
    chk("err", 384'(Err), 384'(m_err));
    chk("req_addr", 384'(Mem_ReqAddr), 384'(m_req_addr));
    chk("req_len", 384'(Mem_ReqLen), 384'(m_req_len));
    chk("line_addr", 384'(LineAddress), 384'(m_line_addr));
    chk("crt_data", 384'(CrtData), 384'(m_crt_data));
    chk("line_data", 384'(LineData), 384'(ml));
  end

  // ---------------- memory responder / fill driver ------------------
  int          r_first, r_done, r_end, r_fw, r_beats;
  logic [31:0] r_crt, r_req_addr;
  logic        r_err;
  logic [255:0] r_line;

  task automatic fill(input logic [31:0] addr, input logic [31:0] base,
                      input int abort_at, input int rq_delay,
                      input int gap, input int bad_beat,
                      input bit no_last, input int hold);
    int cyc, beats, rq_seen;
    bit req_done, rd_fire, req_fire, ok;
    cyc = 1; beats = 0; rq_seen = 0; req_done = 0; ok = 0;
    r_first = -1; r_done = -1; r_end = -1; r_fw = 0;
    r_crt = 0; r_req_addr = 0; r_err = 0; r_line = 0;
    WordAddress = addr;
    En = 1;
    Mem_ReqReady = (rq_delay == 0);
    Mem_RdValid = 0; Mem_RdLast = 0; Mem_RdData = 0;
    while (cyc < 400) begin
      @(negedge Clk);
      rd_fire = Mem_RdValid && Mem_RdReady;
      req_fire = Mem_ReqValid && Mem_ReqReady;
      if (Mem_ReqValid) begin
        if (rq_seen == 0) r_req_addr = Mem_ReqAddr;
        rq_seen++;
      end
      if (FirstWord) begin
        r_fw++;
        if (r_first < 0) begin
          r_first = cyc; r_crt = CrtData;
        end
      end
      if (Completed && r_done < 0) begin
        r_done = cyc; r_line = LineData; r_err = Err;
      end
      if (!Busy) begin
        ok = 1; r_end = cyc;
        break;
      end
      @(posedge Clk);
      #1;
      if (req_fire) req_done = 1;
      if (rd_fire) beats++;
      if (abort_at >= 0 && beats >= abort_at && r_done < 0) En = 0;
      if (r_done >= 0 && cyc - r_done >= hold) En = 0;
      WordAddress = $urandom;
      Mem_ReqReady = (rq_seen >= rq_delay);
      Mem_RdValid = req_done && beats < N &&
        (gap == 0 || (gap == 1 && cyc[0]) ||
         (gap == 2 && ($urandom % 2 == 1)));
      Mem_RdData = base + beats;
      if (no_last && beats == N - 1) Mem_RdLast = 0;
      else Mem_RdLast = (beats == N - 1) != (beats == bad_beat);
      cyc++;
    end
    r_beats = beats;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL fill_timeout: got busy expected idle in 400 cycles");
    end
    En = 0; Mem_RdValid = 0; Mem_ReqReady = 0; Mem_RdLast = 0;
  endtask

  logic [383:0] all_out;
  assign all_out = {LineAddress, FirstWord, CrtData, Completed,
                    LineData, Busy, Err, Mem_ReqValid, Mem_ReqAddr,
                    Mem_ReqLen, Mem_RdReady, 14'd0};

  initial begin
    Rst = 1; En = 0; WordAddress = 0;
    Mem_ReqReady = 0; Mem_RdValid = 0; Mem_RdData = 0; Mem_RdLast = 0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs", all_out, 384'(0));
    @(posedge Clk); #1; Rst = 0;
    @(negedge Clk);

    // aligned miss, no wait states
    fill(32'h0000_1040, 32'hA0, -1, 0, 0, -1, 0, 0);
    chk("aligned_req_addr", 384'(r_req_addr), 384'(32'h1040));
    chk("aligned_line_addr", 384'(LineAddress), 384'(32'h1040));
    chk("aligned_first_cyc", 384'(r_first), 384'(3));
    chk("aligned_crt", 384'(r_crt), 384'(32'hA0));
    chk("aligned_done_cyc", 384'(r_done), 384'(10));
    chk("aligned_w0", 384'(r_line[31:0]), 384'(32'hA0));
    chk("aligned_w7", 384'(r_line[255:224]), 384'(32'hA7));

    // wrapping miss, critical offset 7
    fill(32'h0000_205C, 32'hD0, -1, 0, 0, -1, 0, 1);
    chk("wrap_req_addr", 384'(r_req_addr), 384'(32'h205C));
    chk("wrap_crt", 384'(r_crt), 384'(32'hD0));
    chk("wrap_w7", 384'(r_line[255:224]), 384'(32'hD0));
    chk("wrap_w0", 384'(r_line[31:0]), 384'(32'hD1));
    chk("wrap_w6", 384'(r_line[223:192]), 384'(32'hD7));

    // request and beat backpressure
    fill(32'h0000_3008, 32'h50, -1, 3, 1, -1, 0, 2);
    chk("bp_beats", 384'(r_beats), 384'(8));
    chk("bp_first_pulses", 384'(r_fw), 384'(1));
    chk("bp_completed", 384'(r_done > 0), 384'(1));

    // abort after three kept beats, then a clean refill
    fill(32'h0000_4010, 32'h60, 3, 0, 0, -1, 0, 0);
    chk("abort_no_completed", 384'(r_done), 384'(-1));
    chk("abort_beats", 384'(r_beats), 384'(8));
    chk("abort_busy_fall", 384'(r_end), 384'(10));
    fill(32'h0000_4014, 32'h70, -1, 0, 0, -1, 0, 0);
    chk("refill_done_cyc", 384'(r_done), 384'(10));
    chk("refill_crt", 384'(r_crt), 384'(32'h70));

    // early RdLast on beat index 4, then a clean start
    fill(32'h0000_5000, 32'h80, -1, 0, 0, 4, 0, 0);
    chk("early_last_err", 384'(r_err), 384'(1));
    chk("early_last_done", 384'(r_done), 384'(10));
    fill(32'h0000_5020, 32'h90, -1, 0, 0, -1, 0, 0);
    chk("err_cleared", 384'(r_err), 384'(0));
    fill(32'h0000_5040, 32'hB0, -1, 0, 2, -1, 1, 0);
    chk("missing_last_err", 384'(r_err), 384'(1));

    // randomized fills
    for (int t = 0; t < 30; t++) begin
      fill($urandom, $urandom,
           ($urandom % 3 == 0) ? int'($urandom % 8) : -1,
           int'($urandom % 4), int'($urandom % 3),
           ($urandom % 4 == 0) ? int'($urandom % 8) : -1,
           ($urandom % 8 == 0), int'($urandom % 4));
      @(negedge Clk);
    end

    // asynchronous reset in the middle of FILL
    WordAddress = 32'h0000_6020; En = 1; Mem_ReqReady = 1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Mem_RdValid = 1; Mem_RdData = 32'hC0; Mem_RdLast = 0;
    repeat (3) @(posedge Clk);
    #3; Rst = 1;
    #1;
    chk("async_reset_outputs", all_out, 384'(0));
    En = 0; Mem_RdValid = 0; Mem_ReqReady = 0;
    @(posedge Clk); #1; Rst = 0;
    @(negedge Clk);
    fill(32'h0000_7004, 32'hE0, -1, 1, 0, -1, 0, 0);
    chk("post_reset_crt", 384'(r_crt), 384'(32'hE0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
